// File: rtl/px_mem_if.sv
// px_mem_if: display, loader, status and RAM-port signals of the image RAM arbiter
interface px_mem_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 24
);
  logic              DISP_REQ;
  logic [ADDR_W-1:0] DISP_ADDR;
  logic [DATA_W-1:0] DISP_PX;
  logic              DISP_VALID;
  logic              WR_VALID;
  logic              WR_READY;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_PENDING;
  logic              CLR_STATUS;
  logic              STARVE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              MEM_WE;
  logic [DATA_W-1:0] MEM_RDATA;
  modport slave (
    input  DISP_REQ, DISP_ADDR, WR_VALID, WR_ADDR, WR_DATA, CLR_STATUS, MEM_RDATA,
    output DISP_PX, DISP_VALID, WR_READY, WR_PENDING, STARVE, MEM_ADDR, MEM_WDATA, MEM_WE
  );
  modport master (
    output DISP_REQ, DISP_ADDR, WR_VALID, WR_ADDR, WR_DATA, CLR_STATUS, MEM_RDATA,
    input  DISP_PX, DISP_VALID, WR_READY, WR_PENDING, STARVE, MEM_ADDR, MEM_WDATA, MEM_WE
  );
endinterface

// File: rtl/px_mem_arbiter.sv
// px_mem_arbiter: display-priority arbiter sharing one image RAM with a posted-write FIFO
module px_mem_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 24,
  parameter int WBUF_DEPTH = 4,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 1024
) (
  input logic     CLK_PX,
  input logic     RST_n,
  px_mem_if.slave bus
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]    FULL = CW'(WBUF_DEPTH);
  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);
  logic [ADDR_W-1:0] fa_q [WBUF_DEPTH];
  logic [DATA_W-1:0] fd_q [WBUF_DEPTH];
  logic [PTR_W-1:0]  wp_q, rp_q;
  logic [CW-1:0]     count_q, count_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d;
  logic [RD_LATENCY:0] pipe_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, disp_px_q;
  logic              mem_we_q, disp_valid_q, starve_q, starve_d, push, pop;
  assign bus.WR_READY   = count_q != FULL;
  assign bus.WR_PENDING = count_q != '0;
  assign bus.MEM_ADDR   = mem_addr_q;
  assign bus.MEM_WDATA  = mem_wdata_q;
  assign bus.MEM_WE     = mem_we_q;
  assign bus.DISP_PX    = disp_px_q;
  assign bus.DISP_VALID = disp_valid_q;
  assign bus.STARVE     = starve_q;
  // Grant: display always wins, a queued write only takes a slot the display left idle
  always_comb begin
    push     = bus.WR_VALID && count_q != FULL;
    pop      = !bus.DISP_REQ && count_q != '0;
    count_d  = count_q + CW'(push) - CW'(pop);
    scnt_d   = (bus.DISP_REQ && count_q != '0) ? scnt_q + CNT_W'(scnt_q != SMAX) : '0;
    starve_d = scnt_d == SMAX || (starve_q && !bus.CLR_STATUS);
  end
  // FIFO storage has no reset: an entry is only read after it has been written
  always_ff @(posedge CLK_PX)
    if (push) begin
      fa_q[wp_q] <= bus.WR_ADDR;
      fd_q[wp_q] <= bus.WR_DATA;
    end
  // Control state, registered RAM port and read-return pipeline
  always_ff @(posedge CLK_PX or negedge RST_n)
    if (!RST_n) begin
      wp_q         <= '0;
      rp_q         <= '0;
      count_q      <= '0;
      scnt_q       <= '0;
      starve_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      pipe_q       <= '0;
      disp_valid_q <= 1'b0;
      disp_px_q    <= '0;
    end else begin
      wp_q         <= wp_q + PTR_W'(push);
      rp_q         <= rp_q + PTR_W'(pop);
      count_q      <= count_d;
      scnt_q       <= scnt_d;
      starve_q     <= starve_d;
      mem_we_q     <= pop;
      mem_addr_q   <= bus.DISP_REQ ? bus.DISP_ADDR : pop ? fa_q[rp_q] : mem_addr_q;
      mem_wdata_q  <= pop ? fd_q[rp_q] : mem_wdata_q;
      pipe_q       <= {pipe_q[RD_LATENCY-1:0], bus.DISP_REQ};
      disp_valid_q <= pipe_q[RD_LATENCY];
      disp_px_q    <= pipe_q[RD_LATENCY] ? bus.MEM_RDATA : disp_px_q;
    end
endmodule

// File: tb/tb_px_mem_arbiter.sv
// tb_px_mem_arbiter: scoreboard bench for the display/loader image RAM arbiter
module tb_px_mem_arbiter;
  logic CLK_PX, RST_n;
  int n_chk, n_err, cyc, nwe, nv, n_acc;
  logic acc, ev;
  logic [40:0] w;
  typedef struct { logic [23:0] px; int due; } rd_t;
  rd_t r;
  rd_t dq[$];
  logic [40:0] wq[$];
  logic [23:0] ram [256];
  bit ram_f [256];
  logic [23:0] sh [256];
  bit sh_f [256];
  px_mem_if #(.ADDR_W(17), .DATA_W(24)) bus ();
  px_mem_arbiter #(.STARVE_MAX(8)) dut (.CLK_PX(CLK_PX), .RST_n(RST_n), .bus(bus));
  initial begin
    CLK_PX = 1'b0;
    forever #5 CLK_PX = ~CLK_PX;
  end
  always @(posedge CLK_PX) cyc <= cyc + 1;
  // Image RAM: one-cycle registered read, never-written words hold addr*3
  always @(posedge CLK_PX) begin
    bus.MEM_RDATA <= ram_f[bus.MEM_ADDR[7:0]] ? ram[bus.MEM_ADDR[7:0]] : 24'(bus.MEM_ADDR * 3);
    if (bus.MEM_WE) begin
      ram[bus.MEM_ADDR[7:0]]   <= bus.MEM_WDATA;
      ram_f[bus.MEM_ADDR[7:0]] <= 1'b1;
    end
  end
  function automatic logic [23:0] exp_px(input logic [16:0] a);
    return sh_f[a[7:0]] ? sh[a[7:0]] : 24'(a * 3);
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK_PX);
    #1;
  endtask
  // Scoreboard: queue accepted writes and requested reads, retire them as the DUT emits them
  always @(negedge CLK_PX) begin
    if (!RST_n) begin
      dq.delete();
      wq.delete();
    end else begin
      if (bus.MEM_WE) begin
        if (wq.size() == 0) chk("we_spurious", bus.MEM_WE, 0);
        else begin
          w = wq.pop_front();
          chk("we_addr", bus.MEM_ADDR, w[40:24]);
          chk("we_data", bus.MEM_WDATA, w[23:0]);
          sh[w[31:24]]   <= w[23:0];
          sh_f[w[31:24]] <= 1'b1;
        end
      end
      ev = dq.size() != 0 && dq[0].due == cyc;
      if (ev || bus.DISP_VALID) begin
        chk("disp_valid", bus.DISP_VALID, ev);
        if (ev) begin
          r = dq.pop_front();
          chk("disp_px", bus.DISP_PX, r.px);
        end
      end
      if (bus.WR_VALID && bus.WR_READY) wq.push_back({bus.WR_ADDR, bus.WR_DATA});
      if (bus.DISP_REQ) dq.push_back('{exp_px(bus.DISP_ADDR), cyc + 3});
    end
  end
  initial begin
    RST_n = 1'b0;
    bus.DISP_REQ = 1'b0;
    bus.DISP_ADDR = '0;
    bus.WR_VALID = 1'b1;
    bus.WR_ADDR = 17'd7;
    bus.WR_DATA = 24'h777777;
    bus.CLR_STATUS = 1'b0;
    repeat (2) tick;
    chk("rst_mem_addr", bus.MEM_ADDR, 0);
    chk("rst_mem_wdata", bus.MEM_WDATA, 0);
    chk("rst_mem_we", bus.MEM_WE, 0);
    chk("rst_disp_px", bus.DISP_PX, 0);
    chk("rst_disp_valid", bus.DISP_VALID, 0);
    chk("rst_starve", bus.STARVE, 0);
    chk("rst_pending", bus.WR_PENDING, 0);
    chk("rst_ready", bus.WR_READY, 1);
    bus.WR_VALID = 1'b0;
    RST_n = 1'b1;
    tick;
    // display-only burst over addresses 0..5
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      bus.DISP_REQ = i < 6;
      bus.DISP_ADDR = 17'(i);
      tick;
      nv += int'(bus.DISP_VALID);
      if (i == 1) chk("t2_lat_pre", bus.DISP_VALID, 0);
      if (i == 2) chk("t2_first_valid", bus.DISP_VALID, 1);
      if (i == 7) chk("t2_last_px", bus.DISP_PX, 15);
      chk("t2_no_we", bus.MEM_WE, 0);
    end
    chk("t2_valid_cycles", nv, 6);
    // idle writes drain back to back, then read back
    bus.WR_VALID = 1'b1;
    bus.WR_ADDR = 17'd10;
    bus.WR_DATA = 24'hFF0000;
    tick;
    chk("t3_we_push_edge", bus.MEM_WE, 0);
    bus.WR_ADDR = 17'd11;
    bus.WR_DATA = 24'h00FF00;
    tick;
    chk("t3_we1", bus.MEM_WE, 1);
    chk("t3_addr1", bus.MEM_ADDR, 10);
    bus.WR_ADDR = 17'd12;
    bus.WR_DATA = 24'h0000FF;
    tick;
    chk("t3_we2", bus.MEM_WE, 1);
    chk("t3_addr2", bus.MEM_ADDR, 11);
    bus.WR_VALID = 1'b0;
    tick;
    chk("t3_we3", bus.MEM_WE, 1);
    chk("t3_addr3", bus.MEM_ADDR, 12);
    tick;
    chk("t3_we_end", bus.MEM_WE, 0);
    for (int i = 10; i < 13; i++) begin
      bus.DISP_REQ = 1'b1;
      bus.DISP_ADDR = 17'(i);
      tick;
    end
    bus.DISP_REQ = 1'b0;
    repeat (4) tick;
    chk("t3_readback_px", bus.DISP_PX, 24'h0000FF);
    // reset in the middle of draining three queued writes
    bus.DISP_REQ = 1'b1;
    bus.DISP_ADDR = 17'd5;
    bus.WR_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.WR_ADDR = 17'(100 + i);
      bus.WR_DATA = 24'(24'h0C0000 + i);
      tick;
    end
    bus.DISP_REQ = 1'b0;
    bus.WR_VALID = 1'b0;
    tick;
    chk("t1_drain_we", bus.MEM_WE, 1);
    chk("t1_drain_pending", bus.WR_PENDING, 1);
    #3 RST_n = 1'b0;
    #1;
    chk("t1_mem_addr", bus.MEM_ADDR, 0);
    chk("t1_mem_wdata", bus.MEM_WDATA, 0);
    chk("t1_mem_we", bus.MEM_WE, 0);
    chk("t1_disp_px", bus.DISP_PX, 0);
    chk("t1_disp_valid", bus.DISP_VALID, 0);
    chk("t1_pending", bus.WR_PENDING, 0);
    chk("t1_ready", bus.WR_READY, 1);
    repeat (2) tick;
    RST_n = 1'b1;
    nwe = 0;
    repeat (6) begin
      tick;
      nwe += int'(bus.MEM_WE);
    end
    chk("t1_no_we_after", nwe, 0);
    chk("t1_pending_after", bus.WR_PENDING, 0);
    // full FIFO while display holds the RAM
    bus.DISP_REQ = 1'b1;
    bus.DISP_ADDR = 17'd20;
    bus.WR_VALID = 1'b1;
    bus.WR_ADDR = 17'd40;
    bus.WR_DATA = 24'h00AB00;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      acc = bus.WR_READY;
      tick;
      bus.DISP_ADDR = bus.DISP_ADDR + 17'd1;
      if (acc) begin
        n_acc++;
        bus.WR_ADDR = 17'(40 + n_acc);
        bus.WR_DATA = 24'(24'h00AB00 + n_acc);
      end
    end
    chk("t4_accepted", n_acc, 4);
    chk("t4_full_ready", bus.WR_READY, 0);
    chk("t4_full_pending", bus.WR_PENDING, 1);
    bus.DISP_REQ = 1'b0;
    tick;
    chk("t4_ready_back", bus.WR_READY, 1);
    nwe = int'(bus.MEM_WE);
    tick;
    nwe += int'(bus.MEM_WE);
    bus.WR_VALID = 1'b0;
    repeat (4) begin
      tick;
      nwe += int'(bus.MEM_WE);
    end
    chk("t4_we_count", nwe, 5);
    chk("t4_drained", bus.WR_PENDING, 0);
    chk("t4_no_starve", bus.STARVE, 0);
    repeat (3) tick;
    // read and queued write collide for one cycle
    bus.WR_VALID = 1'b1;
    bus.WR_ADDR = 17'd50;
    bus.WR_DATA = 24'h505050;
    tick;
    bus.WR_VALID = 1'b0;
    bus.DISP_REQ = 1'b1;
    bus.DISP_ADDR = 17'd31;
    tick;
    chk("t5_read_we", bus.MEM_WE, 0);
    chk("t5_read_addr", bus.MEM_ADDR, 31);
    chk("t5_held_pending", bus.WR_PENDING, 1);
    bus.DISP_REQ = 1'b0;
    tick;
    chk("t5_write_we", bus.MEM_WE, 1);
    chk("t5_write_addr", bus.MEM_ADDR, 50);
    chk("t5_write_pending", bus.WR_PENDING, 0);
    repeat (4) tick;
    // write starved by continuous display reads
    bus.DISP_REQ = 1'b1;
    bus.DISP_ADDR = 17'd60;
    bus.WR_VALID = 1'b1;
    bus.WR_ADDR = 17'd90;
    bus.WR_DATA = 24'h123456;
    tick;
    bus.WR_VALID = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      bus.DISP_ADDR = 17'(60 + i);
      tick;
      if (i == 7) chk("t6_starve_pre", bus.STARVE, 0);
      if (i == 8) chk("t6_starve_set", bus.STARVE, 1);
    end
    bus.DISP_REQ = 1'b0;
    tick;
    chk("t6_drain_we", bus.MEM_WE, 1);
    repeat (3) tick;
    chk("t6_sticky", bus.STARVE, 1);
    bus.CLR_STATUS = 1'b1;
    tick;
    chk("t6_cleared", bus.STARVE, 0);
    bus.CLR_STATUS = 1'b0;
    repeat (4) tick;
    chk("t6_stays_clear", bus.STARVE, 0);
    chk("sb_reads_left", dq.size(), 0);
    chk("sb_writes_left", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
